// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM port arbiter slice.
package sdram_pkg;

    localparam int SD_ADDR_W  = 26;
    localparam int SD_DATA_W  = 16;
    localparam int NPORTS_MAX = 8;

    // Port identifier wide enough for the largest supported port count
    typedef logic [$clog2(NPORTS_MAX)-1:0] port_id_t;

    // Controller address layout: {chip, bank, row, col}
    typedef struct packed {
        logic        chip;
        logic [1:0]  bank;
        logic [12:0] row;
        logic [9:0]  col;
    } sdram_addr_t;

    // Split a flat controller address into its fields
    function automatic sdram_addr_t split_addr(input logic [SD_ADDR_W-1:0] addr);
        return sdram_addr_t'(addr);
    endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of port IDs for reads outstanding in the SDRAM controller.
module sdram_tag_fifo
    import sdram_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  logic     pop,
    input  port_id_t din,
    output port_id_t dout,
    output logic     full,
    output logic     empty
);

    localparam int AW = $clog2(DEPTH);

    port_id_t       mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    // Storage write; contents need no reset because count gates the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between
// NPORTS requesters, with in-order routing of returned read data.
module sdram_port_arbiter
    import sdram_pkg::*;
#(
    parameter int NPORTS    = 4,
    parameter int TAG_DEPTH = 4,
    parameter int ADDR_W    = SD_ADDR_W,
    parameter int DATA_W    = SD_DATA_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NPORTS-1:0]             p_read,
    input  logic [NPORTS-1:0]             p_write,
    input  logic [NPORTS-1:0][ADDR_W-1:0] p_addr,
    input  logic [NPORTS-1:0][DATA_W-1:0] p_wdata,
    output logic [NPORTS-1:0]             p_ready,
    output logic [DATA_W-1:0]             p_rdata,
    output logic [NPORTS-1:0]             p_rdata_val,
    output logic                          sd_read,
    output logic                          sd_write,
    output logic [ADDR_W-1:0]             sd_addr,
    output logic [DATA_W-1:0]             sd_wdata,
    input  logic                          sd_cmd_ready,
    input  logic [DATA_W-1:0]             sd_rdata,
    input  logic                          sd_rdata_val,
    output logic                          orphan_err
);

    localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     grant_id;
    logic              grant_valid;
    logic              grant_is_write;
    logic              accept;
    logic [NPORTS-1:0] eligible;
    logic              tag_full;
    logic              tag_empty;
    logic              tag_push;
    port_id_t          tag_head;

    // First eligible port at or after start, wrapping; 0 when none
    function automatic logic [PW-1:0] rr_pick(input logic [NPORTS-1:0] elig,
                                              input logic [PW-1:0]     start);
        logic [PW-1:0] pick;
        logic [PW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NPORTS; k++) begin
            idx = PW'((32'(start) + k) % NPORTS);
            if (!found && elig[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // Eligibility uses the registered full flag, so a same-cycle pop never frees a slot early
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NPORTS; i++) begin
            eligible[i] = p_write[i] || (p_read[i] && !tag_full);
        end
    end

    assign grant_valid    = |eligible;
    assign grant_id       = rr_pick(eligible, rr_ptr);
    assign grant_is_write = p_write[grant_id];
    assign accept         = grant_valid && sd_cmd_ready;
    assign tag_push       = accept && !grant_is_write;

    // Zero-latency forwarding of the granted command; port 0 operands when idle
    always_comb begin
        sd_read  = grant_valid && !grant_is_write;
        sd_write = grant_valid && grant_is_write;
        sd_addr  = p_addr[grant_id];
        sd_wdata = p_wdata[grant_id];
        p_ready  = '0;
        if (accept) begin
            p_ready[grant_id] = 1'b1;
        end
    end

    // Read-data steering to the port at the head of the tag FIFO
    always_comb begin
        p_rdata     = sd_rdata;
        p_rdata_val = '0;
        if (sd_rdata_val && !tag_empty) begin
            for (int unsigned i = 0; i < NPORTS; i++) begin
                p_rdata_val[i] = (tag_head == port_id_t'(i));
            end
        end
    end

    // Round-robin pointer advances past the accepted port; sticky orphan flag
    always_ff @(posedge clk) begin
        if (!reset) begin
            rr_ptr     <= '0;
            orphan_err <= 1'b0;
        end else begin
            if (accept) begin
                rr_ptr <= (grant_id == PW'(NPORTS - 1)) ? '0 : grant_id + PW'(1);
            end
            if (sd_rdata_val && tag_empty) begin
                orphan_err <= 1'b1;
            end
        end
    end

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tag_push),
        .pop   (sd_rdata_val),
        .din   (port_id_t'(grant_id)),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench for sdram_port_arbiter against a queue-based reference model.
module tb_sdram_port_arbiter;

    localparam int NP = 4;
    localparam int TD = 4;
    localparam int AW = 26;
    localparam int DW = 16;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NP-1:0]         p_read;
    logic [NP-1:0]         p_write;
    logic [NP-1:0][AW-1:0] p_addr;
    logic [NP-1:0][DW-1:0] p_wdata;
    logic [NP-1:0]         p_ready;
    logic [DW-1:0]         p_rdata;
    logic [NP-1:0]         p_rdata_val;
    logic                  sd_read;
    logic                  sd_write;
    logic [AW-1:0]         sd_addr;
    logic [DW-1:0]         sd_wdata;
    logic                  sd_cmd_ready;
    logic [DW-1:0]         sd_rdata;
    logic                  sd_rdata_val;
    logic                  orphan_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_rr;
    int m_tags[$];
    bit m_orphan;
    int m_g;
    bit m_acc;
    bit m_wr;

    always #5 clk = ~clk;

    sdram_port_arbiter #(
        .NPORTS    (NP),
        .TAG_DEPTH (TD),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .p_read       (p_read),
        .p_write      (p_write),
        .p_addr       (p_addr),
        .p_wdata      (p_wdata),
        .p_ready      (p_ready),
        .p_rdata      (p_rdata),
        .p_rdata_val  (p_rdata_val),
        .sd_read      (sd_read),
        .sd_write     (sd_write),
        .sd_addr      (sd_addr),
        .sd_wdata     (sd_wdata),
        .sd_cmd_ready (sd_cmd_ready),
        .sd_rdata     (sd_rdata),
        .sd_rdata_val (sd_rdata_val),
        .orphan_err   (orphan_err)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare outputs mid-cycle, then advance the model to the coming edge
    task automatic step_check();
        int            g;
        bit            wr;
        bit            acc;
        logic [NP-1:0] exp_ready;
        logic [NP-1:0] exp_rval;
        @(negedge clk);
        g = -1;
        for (int k = 0; k < NP; k++) begin
            int i;
            i = (m_rr + k) % NP;
            if (g < 0 && (p_write[i] || (p_read[i] && m_tags.size() < TD))) g = i;
        end
        wr  = (g >= 0) && p_write[g];
        acc = (g >= 0) && sd_cmd_ready;
        check_eq("sd_write", 64'(sd_write), 64'(wr));
        check_eq("sd_read", 64'(sd_read), 64'((g >= 0) && !wr));
        if (g >= 0) begin
            check_eq("sd_addr", 64'(sd_addr), 64'(p_addr[g]));
            check_eq("sd_wdata", 64'(sd_wdata), 64'(p_wdata[g]));
        end
        exp_ready = acc ? (NP'(1) << g) : '0;
        exp_rval  = (sd_rdata_val && m_tags.size() > 0) ? (NP'(1) << m_tags[0]) : '0;
        check_eq("p_ready", 64'(p_ready), 64'(exp_ready));
        check_eq("p_rdata_val", 64'(p_rdata_val), 64'(exp_rval));
        check_eq("p_rdata", 64'(p_rdata), 64'(sd_rdata));
        check_eq("orphan_err", 64'(orphan_err), 64'(m_orphan));
        m_g   = g;
        m_acc = acc;
        m_wr  = wr;
        if (!reset) begin
            m_rr = 0;
            m_tags.delete();
            m_orphan = 1'b0;
        end else begin
            if (sd_rdata_val) begin
                if (m_tags.size() > 0) void'(m_tags.pop_front());
                else m_orphan = 1'b1;
            end
            if (acc) begin
                if (!wr) m_tags.push_back(g);
                m_rr = (g + 1) % NP;
            end
        end
    endtask

    // One clock of randomized stimulus; requests are held until accepted
    task automatic cycle(input int rq, input int rt, input int rd, input bit orphan_pulse, input bit rst);
        for (int i = 0; i < NP; i++) begin
            if (!p_read[i] && !p_write[i] && ($urandom % 100) < rq) begin
                int k;
                k = $urandom % 10;
                p_read[i]  = (k < 5) || (k >= 8);
                p_write[i] = (k >= 5);
                p_addr[i]  = AW'($urandom);
                p_wdata[i] = DW'($urandom);
            end
        end
        sd_cmd_ready = ($urandom % 100) < rd;
        sd_rdata_val = orphan_pulse || (m_tags.size() > 0 && ($urandom % 100) < rt);
        sd_rdata     = DW'($urandom);
        reset        = !rst;
        step_check();
        @(posedge clk);
        #1;
        if (m_acc) begin
            if (m_wr) p_write[m_g] = 1'b0;
            else      p_read[m_g]  = 1'b0;
        end
    endtask

    initial begin
        reset        = 1'b0;
        p_read       = '0;
        p_write      = '0;
        p_addr       = '0;
        p_wdata      = '0;
        sd_cmd_ready = 1'b0;
        sd_rdata     = '0;
        sd_rdata_val = 1'b0;
        m_rr         = 0;
        m_orphan     = 1'b0;
        m_acc        = 1'b0;
        m_wr         = 1'b0;
        m_g          = 0;
        repeat (2) @(posedge clk);
        #1;
        cycle(0, 0, 100, 1'b0, 1'b1);
        repeat (3) cycle(0, 0, 100, 1'b0, 1'b0);
        repeat (600) cycle(60, 25, 80, 1'b0, 1'b0);
        repeat (300) cycle(90, 5, 90, 1'b0, 1'b0);
        repeat (150) cycle(70, 30, 20, 1'b0, 1'b0);
        repeat (80)  cycle(0, 100, 100, 1'b0, 1'b0);
        cycle(0, 0, 100, 1'b1, 1'b0);
        if (m_orphan) begin
            repeat (10) cycle(0, 0, 100, 1'b0, 1'b0);
            check_eq("orphan_sticky", 64'(orphan_err), 64'(1));
        end else begin
            errors++;
            $display("FAIL orphan_setup: got %0d tags expected 0", m_tags.size());
        end
        cycle(0, 0, 100, 1'b0, 1'b1);
        repeat (5) cycle(0, 0, 100, 1'b0, 1'b0);
        check_eq("orphan_cleared", 64'(orphan_err), 64'(0));
        repeat (300) cycle(50, 40, 70, 1'b0, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SOC command interface of the SDRAM controller between NPORTS requesters using round-robin arbitration.
- Tracks the port ID of every outstanding read in an in-order tag FIFO, so each returned read word is steered to the port that issued it.
- Sits between the SOC masters (video, CPU, DMA) and the SDRAM controller / GPIO wrapper.

Parameters:
NPORTS, 4, number of requester ports (2..8)
TAG_DEPTH, 4, maximum outstanding reads tracked (power of 2, >=2)
ADDR_W, 26, address width {chip, bank[1:0], row[12:0], col[9:0]}
DATA_W, 16, data word width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
p_read  in  NPORTS  per-port read request
p_write  in  NPORTS  per-port write request
p_addr  in  NPORTS x ADDR_W  per-port address
p_wdata  in  NPORTS x DATA_W  per-port write data
p_ready  out  NPORTS  per-port command accepted this cycle
p_rdata  out  DATA_W  read data, broadcast to all ports
p_rdata_val  out  NPORTS  one-hot read-data valid for the owning port
sd_read  out  1  to controller read
sd_write  out  1  to controller write
sd_addr  out  ADDR_W  to controller addr
sd_wdata  out  DATA_W  to controller data_write
sd_cmd_ready  in  1  from controller cmd_ready
sd_rdata  in  DATA_W  from controller data_read
sd_rdata_val  in  1  from controller data_read_val
orphan_err  out  1  sticky: read data returned with no outstanding tag

Behaviour:
- Reset (reset==0 at a clk edge):
  - rr_ptr=0; tag FIFO emptied; orphan_err=0.
  - Outputs are combinational from state plus inputs. With all p_read/p_write low, sd_read=sd_write=0 and p_ready=0.
- Eligibility: port i is eligible when it asserts p_write[i], or asserts p_read[i] while the tag FIFO is not full.
  - If a port asserts both p_read and p_write, only the write is forwarded. The read stays pending.
- Grant:
  - Combinational. Selects the first eligible port searching from rr_ptr upward, modulo NPORTS.
  - The granted port's request, addr and wdata are forwarded to sd_* in the same cycle (zero latency).
  - No grant -> sd_read=sd_write=0; sd_addr and sd_wdata are don't-care, driven with port 0 values.
- Accept:
  - Occurs when a grant exists and sd_cmd_ready==1. Then p_ready[grant]=1 for exactly that cycle; all other p_ready bits are 0.
  - Requesters hold their request and operands stable until p_ready.
  - On accept, rr_ptr <= (grant+1) mod NPORTS.
  - No accept -> rr_ptr holds. A port stalled by sd_cmd_ready keeps its grant, since rr_ptr does not move.
- Tag FIFO:
  - Push the granted port ID on an accepted read.
  - Pop on sd_rdata_val when not empty.
  - Simultaneous push and pop is legal, including when full (a full FIFO plus a same-cycle pop still blocks the push, because eligibility uses the registered full flag) and when empty (pop is ignored and push occurs).
  - Pointers wrap modulo TAG_DEPTH. The count has log2(TAG_DEPTH)+1 bits.
- Return:
  - p_rdata = sd_rdata.
  - When sd_rdata_val==1 and FIFO not empty: p_rdata_val = one-hot of the head ID, in the same cycle.
  - When sd_rdata_val==1 and FIFO empty: p_rdata_val = 0, and orphan_err is set, cleared only by reset.
- Reset mid-operation: reads still in flight in the controller return after reset with an empty FIFO, are dropped, and set orphan_err. This is acceptable; the controller is reset together with the arbiter.
- Writes never consume tags and are never blocked by a full FIFO.

Decomposition:
- sdram_pkg:
  - ADDR_W and DATA_W constants.
  - port_id_t = logic [$clog2(NPORTS_MAX=8)-1:0].
  - The addr field slicing typedef (struct of chip, bank, row, col).
- Sub-module sdram_tag_fifo:
  - Synchronous FIFO of port_id_t, depth TAG_DEPTH.
  - Signals: push, pop, din, dout, full, empty; pop-when-empty ignored.
  - Instantiated once.
- The round-robin search stays in the arbiter as a function.

Test Plan:
1. Reset, then p_read[2]=1, addr=0x0000123, sd_cmd_ready=1:
   - sd_read=1 and sd_addr=0x0000123 the same cycle; p_ready[2]=1.
   - Later sd_rdata_val with 0xBEEF gives p_rdata_val=4'b0100, p_rdata=0xBEEF.
2. All 4 ports hold p_write, sd_cmd_ready=1 for 8 cycles: grants run 0,1,2,3,0,1,2,3, with exactly one p_ready per cycle.
3. sd_cmd_ready=0 for 5 cycles with p_write[1] and p_write[3] held: no p_ready; grant stays on port 1. When ready rises: port 1 is accepted, then port 3.
4. Ports 0,1,2,3,0 issue reads with no returns (TAG_DEPTH=4):
   - The fifth read is blocked; p_write[1] is still accepted meanwhile.
   - One return goes to port 0; next cycle the fifth read is accepted.
   - Returns are routed in order 1,2,3,0.
5. Same-cycle accepted read from port 3 and return for head port 1 with FIFO at count 2: p_rdata_val=4'b0010 and count stays 2.
6. sd_rdata_val pulse with empty FIFO: p_rdata_val=0 and orphan_err=1. orphan_err persists until reset=0 for one cycle.
